// File: rtl/video_timing_pkg.sv
// Shared timing helpers for the pixel-timing receive path.
package video_timing_pkg;

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_e;

  // Total period of one axis: active + front porch + sync + back porch.
  function automatic int total_of(int active, int fp, int sw, int bp);
    return active + fp + sw + bp;
  endfunction

  // Count value at which the sync pulse of an axis rises.
  function automatic int sync_start(int active, int fp);
    return active + fp;
  endfunction

  // Active display is expected only inside the active rectangle.
  function automatic logic pred_active(int h, int v, int act_h, int act_v);
    return (h < act_h) && (v < act_v);
  endfunction

endpackage

// File: rtl/edge_period_meter.sv
// Rising-edge detector plus 16-bit saturating period counter.
// inc_i selects what is counted between edges; on the edge cycle itself the
// counter restarts at inc_i, so a per-cycle meter restarts at 1 while a meter
// counting line strobes starts at 0 and sees exactly one count per line.
module edge_period_meter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sig_i,
  input  logic        inc_i,
  output logic        rise_o,
  output logic [15:0] period_o
);

  logic        sig_q;
  logic        seen_q;
  logic [15:0] cnt_q;
  logic [15:0] per_q;

  assign rise_o   = sig_i & ~sig_q;
  assign period_o = per_q;

  // Edge register, free-running counter, capture on each edge after the first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sig_q  <= 1'b0;
      seen_q <= 1'b0;
      cnt_q  <= '0;
      per_q  <= '0;
    end else begin
      sig_q <= sig_i;
      if (rise_o) begin
        seen_q <= 1'b1;
        if (seen_q) per_q <= cnt_q;
        cnt_q <= {15'd0, inc_i};
      end else if (inc_i && cnt_q != 16'hFFFF) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: rtl/video_sig_recover.sv
// Rebuilds pixel/line counts from hs/vs/ad strobes and tracks timing lock.
module video_sig_recover
  import video_timing_pkg::*;
#(
  parameter int ACTIVE_H_PIXELS = 1280,
  parameter int H_FRONT_PORCH   = 110,
  parameter int H_SYNC_WIDTH    = 40,
  parameter int H_BACK_PORCH    = 220,
  parameter int ACTIVE_LINES    = 720,
  parameter int V_FRONT_PORCH   = 5,
  parameter int V_SYNC_WIDTH    = 5,
  parameter int V_BACK_PORCH    = 20,
  parameter int LOCK_FRAMES     = 2
) (
  input  logic pixel_clk_in,
  input  logic rst_in,
  input  logic hs_in,
  input  logic vs_in,
  input  logic ad_in,
  output logic [$clog2(total_of(ACTIVE_H_PIXELS, H_FRONT_PORCH, H_SYNC_WIDTH, H_BACK_PORCH))-1:0] hcount_out,
  output logic [$clog2(total_of(ACTIVE_LINES, V_FRONT_PORCH, V_SYNC_WIDTH, V_BACK_PORCH))-1:0]   vcount_out,
  output logic        ad_out,
  output logic        nf_out,
  output logic [5:0]  fc_out,
  output logic        locked_out,
  output logic        err_out,
  output logic [15:0] h_period_out,
  output logic [15:0] v_period_out
);

  localparam int TW  = total_of(ACTIVE_H_PIXELS, H_FRONT_PORCH, H_SYNC_WIDTH, H_BACK_PORCH);
  localparam int TL  = total_of(ACTIVE_LINES, V_FRONT_PORCH, V_SYNC_WIDTH, V_BACK_PORCH);
  localparam int HW  = $clog2(TW);
  localparam int VW  = $clog2(TL);
  localparam int TOW = $clog2(2 * TW);
  localparam int GW  = $clog2(LOCK_FRAMES + 1);

  localparam logic [HW-1:0]  H_LAST  = HW'(TW - 1);
  localparam logic [HW-1:0]  H_SYNC  = HW'(sync_start(ACTIVE_H_PIXELS, H_FRONT_PORCH));
  localparam logic [HW-1:0]  H_PRE   = HW'(sync_start(ACTIVE_H_PIXELS, H_FRONT_PORCH) - 1);
  localparam logic [HW-1:0]  H_NF    = HW'(ACTIVE_H_PIXELS);
  localparam logic [VW-1:0]  V_LAST  = VW'(TL - 1);
  localparam logic [VW-1:0]  V_SYNC  = VW'(sync_start(ACTIVE_LINES, V_FRONT_PORCH));
  localparam logic [VW-1:0]  V_PRE   = VW'(sync_start(ACTIVE_LINES, V_FRONT_PORCH) - 1);
  localparam logic [VW-1:0]  V_NF    = VW'(ACTIVE_LINES);
  localparam logic [TOW-1:0] TO_LAST = TOW'(2 * TW - 1);
  localparam logic [GW-1:0]  GOAL    = GW'(LOCK_FRAMES);

  state_e         state_q, state_d;
  logic [HW-1:0]  hcount_q, hcount_d;
  logic [VW-1:0]  vcount_q, vcount_d;
  logic [TOW-1:0] to_q, to_d;
  logic [GW-1:0]  good_q, good_d, good_inc;
  logic [5:0]     fc_q, fc_d;
  logic           ad_q, nf_q, nf_d, err_q, err_d, locked_q;
  logic           hs_rise, vs_rise, h_wrap, timeout, mismatch;

  // hs measured in pixel cycles, vs measured in lines (hs edges).
  edge_period_meter u_hs_meter (
    .clk_i(pixel_clk_in), .rst_i(rst_in), .sig_i(hs_in), .inc_i(1'b1),
    .rise_o(hs_rise), .period_o(h_period_out)
  );

  edge_period_meter u_vs_meter (
    .clk_i(pixel_clk_in), .rst_i(rst_in), .sig_i(vs_in), .inc_i(hs_rise),
    .rise_o(vs_rise), .period_o(v_period_out)
  );

  // Next counts: sync edges re-anchor the counters, otherwise free-run.
  always_comb begin
    h_wrap   = 1'b0;
    hcount_d = hcount_q + 1'b1;
    if (hs_rise) begin
      hcount_d = H_SYNC;
    end else if (hcount_q == H_LAST) begin
      hcount_d = '0;
      h_wrap   = 1'b1;
    end
    vcount_d = vcount_q;
    if (vs_rise)     vcount_d = V_SYNC;
    else if (h_wrap) vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
  end

  // Edge-position checks, active-display prediction and hs watchdog.
  always_comb begin
    timeout  = !hs_rise && (to_q == TO_LAST);
    to_d     = (hs_rise || timeout) ? '0 : to_q + 1'b1;
    mismatch = (hs_rise && hcount_q != H_PRE) ||
               (vs_rise && !(vcount_q == V_PRE && hcount_q == H_LAST)) ||
               (state_q == LOCKED &&
                ad_in != pred_active(int'(hcount_d), int'(vcount_d),
                                     ACTIVE_H_PIXELS, ACTIVE_LINES));
  end

  // Lock state machine; errors are only reported once we have a reference.
  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    good_inc = good_q + 1'b1;
    err_d    = 1'b0;
    unique case (state_q)
      SEARCH: begin
        if (hs_rise) begin
          state_d = TRACK;
          good_d  = '0;
        end
      end
      TRACK, LOCKED: begin
        if (timeout) begin
          state_d = SEARCH;
          good_d  = '0;
          err_d   = 1'b1;
        end else if (mismatch) begin
          state_d = TRACK;
          good_d  = '0;
          err_d   = 1'b1;
        end else if (state_q == TRACK && vs_rise) begin
          if (good_inc == GOAL) begin
            state_d = LOCKED;
            good_d  = '0;
          end else begin
            good_d = good_inc;
          end
        end
      end
      default: state_d = SEARCH;
    endcase
    nf_d = (state_d == LOCKED) && (hcount_d == H_NF) && (vcount_d == V_NF);
    fc_d = nf_d ? fc_q + 6'd1 : fc_q;
  end

  // All state and outputs registered behind a synchronous reset.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state_q  <= SEARCH;
      hcount_q <= '0;
      vcount_q <= '0;
      to_q     <= '0;
      good_q   <= '0;
      fc_q     <= '0;
      ad_q     <= 1'b0;
      nf_q     <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      to_q     <= to_d;
      good_q   <= good_d;
      fc_q     <= fc_d;
      ad_q     <= ad_in;
      nf_q     <= nf_d;
      err_q    <= err_d;
      locked_q <= (state_d == LOCKED);
    end
  end

  assign hcount_out = hcount_q;
  assign vcount_out = vcount_q;
  assign ad_out     = ad_q;
  assign nf_out     = nf_q;
  assign fc_out     = fc_q;
  assign err_out    = err_q;
  assign locked_out = locked_q;

endmodule

// File: doc/video_sig_recover.md
Name: video_sig_recover

Overview:
- Receive side of the pixel-timing interface: samples hs/vs/active-display strobes, rebuilds hcount/vcount, frame pulse and frame counter, and checks them against the nominal timing.
- Sits behind any timing source (video_sig_gen loopback, sync-stripping input path).
- Gives downstream pixel pipelines coordinates, lock status and error flags, with period measurement for debug.

Parameters:
- ACTIVE_H_PIXELS, 1280, active pixels per line
- H_FRONT_PORCH, 110, cycles from end of active to hs rise
- H_SYNC_WIDTH, 40, hs high cycles
- H_BACK_PORCH, 220, cycles from hs fall to line end
- ACTIVE_LINES, 720, active lines per frame
- V_FRONT_PORCH, 5, lines from end of active to vs rise
- V_SYNC_WIDTH, 5, vs high lines
- V_BACK_PORCH, 20, lines from vs fall to frame end
- LOCK_FRAMES, 2, consecutive clean frames required for lock

Ports:
- pixel_clk_in  in  1  pixel clock
- rst_in  in  1  synchronous active-high reset
- hs_in  in  1  horizontal sync, active high
- vs_in  in  1  vertical sync, active high
- ad_in  in  1  active display
- hcount_out  out  $clog2(TOTAL_WIDTH)  recovered pixel index
- vcount_out  out  $clog2(TOTAL_LINES)  recovered line index
- ad_out  out  1  ad_in delayed 1 cycle, aligned to counts
- nf_out  out  1  one-cycle new-frame pulse
- fc_out  out  6  frame counter
- locked_out  out  1  timing locked
- err_out  out  1  one-cycle error pulse
- h_period_out  out  16  last measured cycles between hs rising edges
- v_period_out  out  16  last measured lines between vs rising edges

Behaviour:
- Derived constants:
  - TOTAL_WIDTH = sum of H params; TOTAL_LINES = sum of V params.
  - HS_START = ACTIVE_H_PIXELS + H_FRONT_PORCH.
  - VS_START = ACTIVE_LINES + V_FRONT_PORCH.
- Reset: every output 0; state SEARCH; internal edge registers 0.
- Latency: all outputs registered. Outputs in cycle t+1 reflect inputs sampled in cycle t. When driven by a compliant source, hcount_out/vcount_out equal the source counts delayed 1 cycle.
- Edge detection: hs_rise = hs_in & ~hs_q. vs_rise = vs_in & ~vs_q.
- hcount update, every cycle:
  - On hs_rise: load HS_START.
  - Otherwise: increment, and wrap TOTAL_WIDTH-1 -> 0.
- vcount update:
  - On vs_rise: load VS_START.
  - Otherwise, on hcount wrap: increment, and wrap TOTAL_LINES-1 -> 0.
  - vs_rise has priority over a simultaneous wrap increment.
  - vs_rise is expected in the same sample as the hcount wrap to 0.
- State machine:
  - SEARCH -> TRACK on first hs_rise.
  - TRACK -> LOCKED after LOCK_FRAMES consecutive vs_rise events with no mismatch.
  - Any mismatch in TRACK or LOCKED -> TRACK, good-frame count cleared.
  - Timeout -> SEARCH.
- Mismatch conditions:
  - hs_rise sampled while hcount_out != HS_START-1.
  - vs_rise sampled while (vcount_out, hcount_out) != (VS_START-1, TOTAL_WIDTH-1).
  - In LOCKED only: ad_in differs from the predicted active flag, evaluated on the next count values.
- Timeout: no hs_rise for 2*TOTAL_WIDTH cycles.
- err_out: one-cycle pulse on each mismatch or timeout while in TRACK or LOCKED. Never pulses in SEARCH.
- locked_out = (state == LOCKED). It drops on the cycle err_out pulses.
- nf_out:
  - Pulses one cycle when hcount_out becomes ACTIVE_H_PIXELS while vcount_out == ACTIVE_LINES and locked_out = 1.
  - fc_out increments (6-bit wrap) in the same cycle.
  - No nf_out while unlocked; fc_out holds.
- Period measurement:
  - A 16-bit free-running period counter restarts at 1 on each hs_rise, after its value is captured into h_period_out. It saturates at 0xFFFF.
  - v_period_out uses the same scheme, counting hs_rise events between vs_rise events.
  - The first measurement after reset is discarded; the output stays 0 until the second edge.
- In SEARCH, counts free-run and are undefined for consumers; consumers gate on locked_out.

Decomposition:
- Shared package video_timing_pkg holds:
  - TOTAL_WIDTH, TOTAL_LINES, HS_START, VS_START derivation functions.
  - The state enum {SEARCH, TRACK, LOCKED}.
  - The predicted-active-display function.
- One sub-module: edge_period_meter (rise detect, 16-bit saturating period counter, capture register). Instantiated twice: hs on every cycle, vs on hs_rise enable.

Test Plan:
- Loopback from video_sig_gen, default params, 3 frames -> locked_out rises at end of frame 2 (second vs_rise). hcount_out/vcount_out equal generator counts delayed 1 cycle from then on. err_out never asserts. h_period_out=1650, v_period_out=750.
- Locked loopback -> nf_out one cycle after generator nf_out, with fc_out incrementing 0->1->2 across frames.
- Delay one hs rising edge by 1 cycle on line 100 -> single err_out pulse, locked_out drops. hcount_out realigns to 1390 on that edge. Relock after 2 clean frames.
- Hold hs_in low for 3300 cycles while locked -> err_out pulse at timeout, state SEARCH, locked_out=0. Resume hs -> TRACK, then LOCKED.
- Force ad_in=0 at pixel (500, 300) while locked -> err_out pulse, locked_out=0. Counts continue uninterrupted.
- Assert rst_in for 1 cycle mid-frame -> next cycle all outputs 0, state SEARCH. Relock within 2 full frames after the next hs_rise.
